// File: rtl/lpm_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package lpm_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

  // Widest operand the magnitude helper supports.
  localparam int MAXW = 64;

  // Iteration counter width; it has to hold WIDTHN-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Conditional two's-complement negate.
  // With a sign-extended input this yields the magnitude, so the most negative value still fits.
  function automatic logic [MAXW:0] neg_if(input logic [MAXW:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/lpm_div_step.sv
// One restoring-division step: shift in a dividend bit and subtract the divisor when it fits.
module lpm_div_step #(
  parameter int WIDTHD = 32
) (
  input  logic [WIDTHD-1:0] partial_i,
  input  logic              bit_i,
  input  logic [WIDTHD-1:0] divisor_i,
  output logic [WIDTHD-1:0] partial_o,
  output logic              qbit_o
);

  logic [WIDTHD:0] shifted;

  assign shifted = {partial_i, bit_i};
  assign qbit_o  = (shifted >= {1'b0, divisor_i});
  // The true difference is below the divisor, so its low WIDTHD bits are exact.
  assign partial_o = qbit_o ? (shifted[WIDTHD-1:0] - divisor_i) : shifted[WIDTHD-1:0];

endmodule

// File: rtl/lpm_div_seq.sv
// Iterative radix-2 restoring divider.
// It produces one quotient bit per cycle and has start/ready and valid/ready handshakes.
module lpm_div_seq #(
  parameter int    WIDTHN         = 32,
  parameter int    WIDTHD         = 32,
  parameter string REPRESENTATION = "UNSIGNED"
) (
  input  logic              i_clock,
  input  logic              i_aclr,
  input  logic              i_sclr,
  input  logic              i_clken,
  input  logic              i_start,
  input  logic [WIDTHN-1:0] i_numer,
  input  logic [WIDTHD-1:0] i_denom,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTHN-1:0] o_quotient,
  output logic [WIDTHD-1:0] o_remain,
  output logic              o_div0
);
  import lpm_div_pkg::*;

  localparam int CNTW      = cnt_width(WIDTHN);
  localparam bit IS_SIGNED = (REPRESENTATION == "SIGNED");

  generate
    if (REPRESENTATION != "UNSIGNED" && REPRESENTATION != "SIGNED") begin : g_bad_rep
      $error("lpm_div_seq: REPRESENTATION must be UNSIGNED or SIGNED");
    end
  endgenerate

  div_state_e        state_q, state_d;
  logic [WIDTHN-1:0] num_q;
  logic [WIDTHD-1:0] den_q, part_q, raw_q;
  logic [CNTW-1:0]   cnt_q;
  logic              sgn_quot_q, sgn_rem_q, div0_q;
  logic [WIDTHN-1:0] quot_q;
  logic [WIDTHD-1:0] rem_q;
  logic              div0_out_q;

  logic              accept, calc_en, fix_en;
  logic [WIDTHD-1:0] step_part;
  logic              step_qbit;
  logic              sn, sd;
  logic [MAXW:0]     numer_ext, denom_ext, numer_abs, denom_abs;
  logic              unused_abs_hi;

  // Operand signs and magnitudes. Unsigned mode forces both signs to zero.
  assign sn        = IS_SIGNED & i_numer[WIDTHN-1];
  assign sd        = IS_SIGNED & i_denom[WIDTHD-1];
  assign numer_ext = {{(MAXW+1-WIDTHN){sn}}, i_numer};
  assign denom_ext = {{(MAXW+1-WIDTHD){sd}}, i_denom};
  assign numer_abs = neg_if(numer_ext, sn);
  assign denom_abs = neg_if(denom_ext, sd);
  assign unused_abs_hi = ^{numer_abs[MAXW:WIDTHN], denom_abs[MAXW:WIDTHD]};

  lpm_div_step #(.WIDTHD(WIDTHD)) u_step (
    .partial_i (part_q),
    .bit_i     (num_q[WIDTHN-1]),
    .divisor_i (den_q),
    .partial_o (step_part),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge i_clock or posedge i_aclr) begin
    if (i_aclr) begin
      state_q <= IDLE;
    end else if (i_clken) begin
      state_q <= i_sclr ? IDLE : state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    accept  = 1'b0;
    calc_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        accept  = i_start & i_clken & ~i_sclr;
      end
      CALC:    calc_en = i_clken & ~i_sclr;
      FIX:     fix_en  = i_clken & ~i_sclr;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  // The working registers are always loaded at accept before they are used, so they need no reset.
  // num_q starts as the dividend magnitude and turns into the quotient magnitude as bits shift in.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      num_q      <= numer_abs[WIDTHN-1:0];
      den_q      <= denom_abs[WIDTHD-1:0];
      part_q     <= '0;
      raw_q      <= i_numer[WIDTHD-1:0];
      sgn_quot_q <= sn ^ sd;
      sgn_rem_q  <= sn;
      div0_q     <= (i_denom == '0);
    end else if (calc_en) begin
      num_q  <= {num_q[WIDTHN-2:0], step_qbit};
      part_q <= step_part;
    end
  end

  always_ff @(posedge i_clock or posedge i_aclr) begin
    if (i_aclr) begin
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div0_out_q <= 1'b0;
    end else if (i_clken) begin
      if (i_sclr) begin
        cnt_q      <= '0;
        quot_q     <= '0;
        rem_q      <= '0;
        div0_out_q <= 1'b0;
      end else begin
        if (accept) begin
          cnt_q <= CNTW'(WIDTHN - 1);
        end else if (calc_en) begin
          cnt_q <= cnt_q - CNTW'(1);
        end
        // Divide by zero overrides the signed fix-up with all-ones and the raw dividend.
        if (fix_en) begin
          quot_q     <= div0_q ? '1 : (sgn_quot_q ? -num_q : num_q);
          rem_q      <= div0_q ? raw_q : (sgn_rem_q ? -part_q : part_q);
          div0_out_q <= div0_q;
        end
      end
    end
  end

  assign o_quotient = quot_q;
  assign o_remain   = rem_q;
  assign o_div0     = div0_out_q;

endmodule

// File: tb/tb_lpm_div_seq.sv
// Bench for lpm_div_seq: four configurations share one stimulus stream.
// The configurations are 8/8 unsigned, 8/8 signed, 32/16 unsigned and 32/16 signed, each checked against integer division.
module tb_lpm_div_seq;

  typedef longint unsigned u64_t;

  localparam int WN [4] = '{8, 8, 32, 32};
  localparam int WD [4] = '{8, 8, 16, 16};
  localparam bit SG [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        aclr, sclr, clken, start, rdy;
  logic [31:0] numer;
  logic [15:0] denom;

  logic        rdy8u, vld8u, z8u, rdy8s, vld8s, z8s;
  logic        rdy32u, vld32u, z32u, rdy32s, vld32s, z32s;
  logic [7:0]  q8u, r8u, q8s, r8s;
  logic [31:0] q32u, q32s;
  logic [15:0] r32u, r32s;

  logic        ordy [4];
  logic        vld  [4];
  logic        zo   [4];
  logic [31:0] qo   [4];
  logic [15:0] ro   [4];

  u64_t got_q [4];
  u64_t got_r [4];
  u64_t got_z [4];
  int   got_lat [4];

  int n_cmp = 0;
  int n_mis = 0;
  int op_idx = 0;

  always #5 clk = ~clk;

  lpm_div_seq #(.WIDTHN(8), .WIDTHD(8), .REPRESENTATION("UNSIGNED")) u_d8u (
    .i_clock(clk), .i_aclr(aclr), .i_sclr(sclr), .i_clken(clken), .i_start(start),
    .i_numer(numer[7:0]), .i_denom(denom[7:0]), .o_ready(rdy8u), .o_valid(vld8u),
    .i_ready(rdy), .o_quotient(q8u), .o_remain(r8u), .o_div0(z8u));

  lpm_div_seq #(.WIDTHN(8), .WIDTHD(8), .REPRESENTATION("SIGNED")) u_d8s (
    .i_clock(clk), .i_aclr(aclr), .i_sclr(sclr), .i_clken(clken), .i_start(start),
    .i_numer(numer[7:0]), .i_denom(denom[7:0]), .o_ready(rdy8s), .o_valid(vld8s),
    .i_ready(rdy), .o_quotient(q8s), .o_remain(r8s), .o_div0(z8s));

  lpm_div_seq #(.WIDTHN(32), .WIDTHD(16), .REPRESENTATION("UNSIGNED")) u_d32u (
    .i_clock(clk), .i_aclr(aclr), .i_sclr(sclr), .i_clken(clken), .i_start(start),
    .i_numer(numer), .i_denom(denom), .o_ready(rdy32u), .o_valid(vld32u),
    .i_ready(rdy), .o_quotient(q32u), .o_remain(r32u), .o_div0(z32u));

  lpm_div_seq #(.WIDTHN(32), .WIDTHD(16), .REPRESENTATION("SIGNED")) u_d32s (
    .i_clock(clk), .i_aclr(aclr), .i_sclr(sclr), .i_clken(clken), .i_start(start),
    .i_numer(numer), .i_denom(denom), .o_ready(rdy32s), .o_valid(vld32s),
    .i_ready(rdy), .o_quotient(q32s), .o_remain(r32s), .o_div0(z32s));

  always_comb begin
    ordy[0] = rdy8u;  vld[0] = vld8u;  zo[0] = z8u;  qo[0] = {24'd0, q8u}; ro[0] = {8'd0, r8u};
    ordy[1] = rdy8s;  vld[1] = vld8s;  zo[1] = z8s;  qo[1] = {24'd0, q8s}; ro[1] = {8'd0, r8s};
    ordy[2] = rdy32u; vld[2] = vld32u; zo[2] = z32u; qo[2] = q32u;        ro[2] = r32u;
    ordy[3] = rdy32s; vld[3] = vld32s; zo[3] = z32s; qo[3] = q32s;        ro[3] = r32s;
  end

  task automatic check_eq(input string tag, input u64_t got, input u64_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating integer division on sign-interpreted operands.
  function automatic void ref_div(input logic [31:0] n, input logic [15:0] d, input int wn,
                                  input int wd, input bit sg, output u64_t q, output u64_t r,
                                  output bit z);
    u64_t   mn, md, nu, du;
    longint ns, ds, qs, rs;
    mn = (64'd1 << wn) - 64'd1;
    md = (64'd1 << wd) - 64'd1;
    nu = {32'd0, n} & mn;
    du = {48'd0, d} & md;
    ns = (sg && nu[wn-1]) ? longint'(nu) - longint'(mn + 64'd1) : longint'(nu);
    ds = (sg && du[wd-1]) ? longint'(du) - longint'(md + 64'd1) : longint'(du);
    z  = (du == 0);
    if (z) begin
      q = mn;
      r = nu & md;
    end else begin
      qs = ns / ds;
      rs = ns % ds;
      q  = u64_t'(qs) & mn;
      r  = u64_t'(rs) & md;
    end
  endfunction

  // One full transaction on all four dividers. It optionally holds i_ready low, gates i_clken and pokes i_start mid-CALC.
  task automatic run_op(input logic [31:0] n, input logic [15:0] d, input int hold,
                        input int gap_at, input int gap_len, input bit poke);
    u64_t eq [4];
    u64_t er [4];
    bit   ez [4];
    bit   seen [4];
    bit   all_seen, all_idle, done;
    int   left, cyc;
    for (int i = 0; i < 4; i++) begin
      ref_div(n, d, WN[i], WD[i], SG[i], eq[i], er[i], ez[i]);
      seen[i] = 1'b0;
    end
    numer = n; denom = d; start = 1'b1; clken = 1'b1; rdy = 1'b0;
    left = hold; done = 1'b0; cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc < 6);
      if (poke && cyc == 1) begin
        numer = ~n;
        denom = d + 16'd3;
      end
      clken = !((cyc + 1) >= gap_at && (cyc + 1) < gap_at + gap_len);
      all_seen = 1'b1;
      all_idle = 1'b1;
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("ready_valid_excl[%0d]", i), u64_t'(ordy[i] & vld[i]), 0);
        if (vld[i] && !seen[i]) begin
          seen[i]    = 1'b1;
          got_q[i]   = qo[i];
          got_r[i]   = ro[i];
          got_z[i]   = u64_t'(zo[i]);
          got_lat[i] = cyc;
          check_eq($sformatf("quot[%0d] op%0d", i, op_idx), got_q[i], eq[i]);
          check_eq($sformatf("rem[%0d] op%0d", i, op_idx), got_r[i], er[i]);
          check_eq($sformatf("div0[%0d] op%0d", i, op_idx), got_z[i], u64_t'(ez[i]));
          check_eq($sformatf("latency[%0d] op%0d", i, op_idx), u64_t'(cyc),
                   u64_t'(WN[i] + 2 + gap_len));
        end
        all_seen &= seen[i];
        all_idle &= ordy[i];
      end
      if (all_seen) begin
        if (rdy) begin
          if (all_idle) begin
            rdy  = 1'b0;
            done = 1'b1;
          end
        end else if (left > 0) begin
          left--;
        end else begin
          for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("hold_quot[%0d]", i), qo[i], got_q[i]);
            check_eq($sformatf("hold_rem[%0d]", i), ro[i], got_r[i]);
            check_eq($sformatf("hold_ready_low[%0d]", i), u64_t'(ordy[i]), 0);
          end
          rdy = 1'b1;
        end
      end
    end
    if (!done) check_eq($sformatf("op%0d_timeout", op_idx), 0, 1);
    $display("op %0d: n=0x%08h d=0x%04h | 8u q=%02h r=%02h z=%0b | 8s q=%02h r=%02h z=%0b | 32u q=%08h r=%04h z=%0b | 32s q=%08h r=%04h z=%0b",
             op_idx, n, d, got_q[0][7:0], got_r[0][7:0], got_z[0][0], got_q[1][7:0], got_r[1][7:0],
             got_z[1][0], got_q[2][31:0], got_r[2][15:0], got_z[2][0], got_q[3][31:0],
             got_r[3][15:0], got_z[3][0]);
    op_idx++;
  endtask

  // Starts 255/1, then clears it mid-CALC with either the async or the sync clear.
  task automatic abort_mid(input bit use_aclr);
    string pfx;
    pfx = use_aclr ? "aclr" : "sclr";
    numer = 32'd255; denom = 16'd1; start = 1'b1; clken = 1'b1; rdy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (use_aclr) begin
      aclr = 1'b1;
      #1;
    end else begin
      sclr = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_ready[%0d]", pfx, i), u64_t'(ordy[i]), 1);
      check_eq($sformatf("%s_valid[%0d]", pfx, i), u64_t'(vld[i]), 0);
      check_eq($sformatf("%s_quot[%0d]", pfx, i), qo[i], 0);
      check_eq($sformatf("%s_rem[%0d]", pfx, i), ro[i], 0);
      check_eq($sformatf("%s_div0[%0d]", pfx, i), u64_t'(zo[i]), 0);
    end
    aclr = 1'b0;
    sclr = 1'b0;
    $display("op %0d: %s abort mid-CALC", op_idx, pfx);
  endtask

  initial begin
    logic [31:0] rn;
    logic [15:0] rd;
    aclr = 1'b1; sclr = 1'b0; clken = 1'b1; start = 1'b0; rdy = 1'b0;
    numer = '0; denom = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("reset_ready[%0d]", i), u64_t'(ordy[i]), 1);
      check_eq($sformatf("reset_valid[%0d]", i), u64_t'(vld[i]), 0);
      check_eq($sformatf("reset_quot[%0d]", i), qo[i], 0);
      check_eq($sformatf("reset_rem[%0d]", i), ro[i], 0);
      check_eq($sformatf("reset_div0[%0d]", i), u64_t'(zo[i]), 0);
    end
    aclr = 1'b0;
    @(posedge clk); #1;

    run_op(32'd200, 16'd7, 5, 0, 0, 1'b0);
    check_eq("u8_200div7_q", got_q[0], 28);
    check_eq("u8_200div7_r", got_r[0], 4);
    check_eq("u8_200div7_z", got_z[0], 0);
    check_eq("u8_200div7_lat", u64_t'(got_lat[0]), 10);

    run_op(32'hFFFF_FFF9, 16'd2, 0, 0, 0, 1'b0);
    check_eq("s8_m7div2_q", got_q[1], 'hFD);
    check_eq("s8_m7div2_r", got_r[1], 'hFF);
    run_op(32'd7, 16'hFFFE, 1, 0, 0, 1'b0);
    check_eq("s8_7divm2_q", got_q[1], 'hFD);
    check_eq("s8_7divm2_r", got_r[1], 'h01);
    run_op(32'hFFFF_FF80, 16'hFFFF, 0, 0, 0, 1'b0);
    check_eq("s8_minneg_q", got_q[1], 'h80);
    check_eq("s8_minneg_r", got_r[1], 0);
    check_eq("s8_minneg_z", got_z[1], 0);

    run_op(32'h5A, 16'd0, 2, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("div0_q[%0d]", i), got_q[i], 'hFF);
      check_eq($sformatf("div0_r[%0d]", i), got_r[i], 'h5A);
      check_eq($sformatf("div0_z[%0d]", i), got_z[i], 1);
      check_eq($sformatf("div0_lat[%0d]", i), u64_t'(got_lat[i]), 10);
    end

    run_op(32'd255, 16'd1, 0, 4, 3, 1'b1);
    check_eq("u8_clken_gap_q", got_q[0], 255);
    check_eq("u8_clken_gap_r", got_r[0], 0);
    check_eq("u8_clken_gap_lat", u64_t'(got_lat[0]), 13);

    abort_mid(1'b1);
    run_op(32'd100, 16'd10, 0, 0, 0, 1'b0);
    check_eq("after_aclr_q", got_q[0], 10);
    check_eq("after_aclr_r", got_r[0], 0);
    abort_mid(1'b0);
    run_op(32'd100, 16'd10, 0, 0, 0, 1'b0);
    check_eq("after_sclr_q", got_q[0], 10);
    check_eq("after_sclr_r", got_r[0], 0);

    for (int k = 0; k < 1000; k++) begin
      case ($urandom_range(0, 7))
        0:       rn = 32'h8000_0000;
        1:       rn = 32'hFFFF_FF80;
        2:       rn = 32'd0;
        default: rn = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rd = 16'd0;
        1:       rd = 16'hFFFF;
        2:       rd = 16'($urandom_range(1, 15));
        3:       rd = 16'h0080;
        default: rd = 16'($urandom);
      endcase
      run_op(rn, rd, $urandom_range(0, 3), 0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
